// File: rtl/vxe_reg_fifo.sv
// vxe_reg_fifo: flip-flop based elastic buffer with valid/ready on both sides.
// It sits between VxEngine pipeline stages and absorbs back-pressure from the
// consumer without stalling the producer.
//
// Optional feature macro: VXE_REG_FIFO_BYPASS_EN
//   When this macro is defined and the buffer is empty, a word offered with
//   in_valid while out_ready is high passes straight through in the same
//   cycle. The word is not stored.
//   When the macro is undefined, every word is registered first, so the
//   latency from input to output is always one cycle.
//
// Ports:
//   clk        clock; all state changes on its rising edge
//   rst        asynchronous, active-high reset
//   in_data    write data (DATA_WIDTH bits)
//   in_valid   the producer is offering in_data
//   in_ready   the buffer can accept a word (equals !full)
//   out_data   data at the head of the queue
//   out_valid  the head entry is valid
//   out_ready  the consumer takes the head word
//   count      number of stored entries, 0..DEPTH
//   full       count == DEPTH
//   empty      count == 0
module vxe_reg_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [DATA_WIDTH-1:0]    in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [DATA_WIDTH-1:0]    out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]         r_wr_ptr;
    logic [AW-1:0]         r_rd_ptr;
    logic [CW-1:0]         r_count;

    logic w_empty;
    logic w_full;
    logic w_bypass;
    logic w_push;
    logic w_pop;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == CW'(DEPTH));

`ifdef VXE_REG_FIFO_BYPASS_EN
    // When a word passes through, it is consumed in the same cycle and
    // never reaches storage.
    assign w_bypass  = w_empty && in_valid && out_ready;
    assign out_valid = !w_empty || w_bypass;
    assign out_data  = w_bypass ? in_data : r_mem[r_rd_ptr];
`else
    assign w_bypass  = 1'b0;
    assign out_valid = !w_empty;
    assign out_data  = r_mem[r_rd_ptr];
`endif

    assign in_ready = !w_full;
    assign full     = w_full;
    assign empty    = w_empty;
    assign count    = r_count;

    // When the buffer is full, a pop still happens, but in_ready was already
    // low, so no push can occur in that cycle.
    assign w_push = in_valid && in_ready && !w_bypass;
    assign w_pop  = !w_empty && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= in_data;
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: tb/tb_vxe_reg_fifo.sv
module tb_vxe_reg_fifo;

    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [CW-1:0] count;
    logic          full;
    logic          empty;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: plain queue of stored words.
    logic [DW-1:0] q[$];

    vxe_reg_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .count(count), .full(full), .empty(empty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock cycle, starting and ending at a falling edge. The task drives
    // the inputs, checks the outputs against the model, and updates the model
    // at the rising edge.
    task automatic step(input logic iv, input logic [DW-1:0] d, input logic ordy,
                        output logic took, output logic gave, output logic [DW-1:0] dout);
        logic byp, exp_ir, exp_ov, do_pop;
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        #1;
        byp = 1'b0;
`ifdef VXE_REG_FIFO_BYPASS_EN
        byp = (q.size() == 0) && iv && ordy;
`endif
        exp_ir = q.size() < DEPTH;
        exp_ov = (q.size() > 0) || byp;
        chk("count", 64'(count), 64'(q.size()));
        chk("empty", 64'(empty), 64'(q.size() == 0));
        chk("full", 64'(full), 64'(q.size() == DEPTH));
        chk("in_ready", 64'(in_ready), 64'(exp_ir));
        chk("out_valid", 64'(out_valid), 64'(exp_ov));
        if (exp_ov) chk("out_data", 64'(out_data), 64'(byp ? d : q[0]));
        dout   = out_data;
        took   = iv && exp_ir;
        do_pop = (q.size() > 0) && ordy;
        gave   = do_pop || byp;
        @(posedge clk);
        if (do_pop) void'(q.pop_front());
        if (took && !byp) q.push_back(d);
        @(negedge clk);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_count"}, 64'(count), 64'(0));
        chk({tag, "_empty"}, 64'(empty), 64'(1));
        chk({tag, "_full"}, 64'(full), 64'(0));
        chk({tag, "_in_ready"}, 64'(in_ready), 64'(1));
        chk({tag, "_out_valid"}, 64'(out_valid), 64'(0));
        chk({tag, "_out_data"}, 64'(out_data), 64'(0));
    endtask

    initial begin
        logic tk, gv;
        logic [DW-1:0] dv;
        logic [DW-1:0] pend;
        logic          pend_v;
        int            rx, tx, k, guard;
        logic [DW-1:0] fill_exp [5];

        repeat (3) @(negedge clk);
        #1 chk_reset_state("por");
        @(negedge clk);
        rst = 1'b0;

        // Push two words, then assert reset in the middle of a transfer.
        step(1'b1, 32'haaaa_0001, 1'b0, tk, gv, dv);
        step(1'b1, 32'haaaa_0002, 1'b0, tk, gv, dv);
        in_valid = 1'b1; in_data = 32'haaaa_0003; out_ready = 1'b1;
        #2 rst = 1'b1;
        #1 chk_reset_state("rst_async");
        repeat (3) @(negedge clk);
        chk_reset_state("rst_hold");
        q.delete();
        rst = 1'b0;
        step(1'b0, '0, 1'b1, tk, gv, dv);
        chk("rst_no_ghost", 64'(out_valid), 64'(0));

        // Single word.
        step(1'b1, 32'hfefe_0000, 1'b0, tk, gv, dv);
        chk("single_ov", 64'(out_valid), 64'(1));
        chk("single_od", 64'(out_data), 64'hfefe_0000);
        chk("single_cnt", 64'(count), 64'(1));
        step(1'b0, '0, 1'b1, tk, gv, dv);
        chk("single_empty", 64'(empty), 64'(1));

        // Fill and stall.
        for (int i = 1; i <= 4; i++) step(1'b1, DW'(i), 1'b0, tk, gv, dv);
        chk("fill_full", 64'(full), 64'(1));
        chk("fill_in_ready", 64'(in_ready), 64'(0));
        chk("fill_cnt", 64'(count), 64'(4));
        step(1'b1, 32'h5, 1'b0, tk, gv, dv);
        chk("stall_held", 64'(tk), 64'(0));
        for (int i = 0; i < 5; i++) fill_exp[i] = DW'(i + 1);
        k = 0;
        step(1'b1, 32'h5, 1'b1, tk, gv, dv);
        chk("stall_no_push", 64'(tk), 64'(0));
        if (gv) begin chk("fill_order", 64'(dv), 64'(fill_exp[k])); k++; end
        chk("stall_ready_rise", 64'(in_ready), 64'(1));
        step(1'b1, 32'h5, 1'b1, tk, gv, dv);
        if (gv) begin chk("fill_order", 64'(dv), 64'(fill_exp[k])); k++; end
        guard = 0;
        while (k < 5 && guard < 20) begin
            step(1'b0, '0, 1'b1, tk, gv, dv);
            if (gv) begin chk("fill_order", 64'(dv), 64'(fill_exp[k])); k++; end
            guard++;
        end
        chk("fill_all_rx", 64'(k), 64'(5));

        // Wrap-around streaming.
        tx = 0; rx = 0; guard = 0;
        while (rx < 12 && guard < 100) begin
            step(tx < 12, 32'hbebe_0000 + DW'(tx), (guard % 3) != 2, tk, gv, dv);
            if (gv) begin chk("wrap_order", 64'(dv), 64'(32'hbebe_0000 + DW'(rx))); rx++; end
            if (tk && tx < 12) tx++;
            chk("wrap_cnt_le4", 64'(count <= CW'(DEPTH)), 64'(1));
            guard++;
        end
        chk("wrap_all_rx", 64'(rx), 64'(12));

        // Simultaneous push and pop at count 2.
        step(1'b1, 32'hc0c0_0001, 1'b0, tk, gv, dv);
        step(1'b1, 32'hc0c0_0002, 1'b0, tk, gv, dv);
        step(1'b1, 32'hc0c0_0003, 1'b1, tk, gv, dv);
        chk("sim_cnt", 64'(count), 64'(2));
        chk("sim_head", 64'(out_data), 64'hc0c0_0002);
        step(1'b0, '0, 1'b1, tk, gv, dv);
        step(1'b0, '0, 1'b1, tk, gv, dv);
        chk("sim_drained", 64'(empty), 64'(1));

        // Bypass / one-cycle latency from an empty buffer.
        in_valid = 1'b1; in_data = 32'h1234_5678; out_ready = 1'b1;
        #1;
`ifdef VXE_REG_FIFO_BYPASS_EN
        chk("byp_ov", 64'(out_valid), 64'(1));
        chk("byp_od", 64'(out_data), 64'h1234_5678);
        step(1'b1, 32'h1234_5678, 1'b1, tk, gv, dv);
        chk("byp_cnt", 64'(count), 64'(0));
`else
        chk("lat_ov0", 64'(out_valid), 64'(0));
        step(1'b1, 32'h1234_5678, 1'b1, tk, gv, dv);
        chk("lat_ov1", 64'(out_valid), 64'(1));
        chk("lat_od1", 64'(out_data), 64'h1234_5678);
        step(1'b0, '0, 1'b1, tk, gv, dv);
`endif

        // Randomized traffic against the queue model; the producer holds a
        // word until it is accepted.
        pend_v = 1'b0; pend = '0;
        for (int c = 0; c < 600; c++) begin
            if (!pend_v && ($urandom_range(0, 3) != 0)) begin
                pend_v = 1'b1;
                pend   = $urandom;
            end
            step(pend_v, pend, $urandom_range(0, 1) == 1, tk, gv, dv);
            if (tk) pend_v = 1'b0;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected finish before 200000");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/vxe_reg_fifo.md
# vxe_reg_fifo

Parametrised, register-based elastic buffer: the successor to the plain write-enabled data register, adding depth, valid/ready flow control on both sides, and occupancy status. Sits between VxEngine pipeline stages, for example between instruction fetch and the vector unit dispatch, to absorb back-pressure without stalling the producer. Storage is flip-flops only, with no SRAM, and is intended for small depths.

## Interface
- DATA_WIDTH, 32, width of each data word
- DEPTH, 4, number of entries; power of two, at least 2
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- in_data  in  DATA_WIDTH  write data
- in_valid  in  1  producer has data
- in_ready  out  1  buffer accepts data; equals !full
- out_data  out  DATA_WIDTH  head-of-queue data
- out_valid  out  1  head entry is valid
- out_ready  in  1  consumer takes data
- count  out  $clog2(DEPTH)+1  number of stored entries, 0..DEPTH
- full  out  1  count == DEPTH
- empty  out  1  count == 0

## Operation
- Push occurs when in_valid && in_ready. in_data is written to entry wr_ptr, and wr_ptr increments.
- Pop occurs when out_valid && out_ready, and rd_ptr increments.
- Pointers are $clog2(DEPTH) bits wide and wrap from DEPTH-1 to 0 naturally.
- count update:
  - +1 on push only
  - -1 on pop only
  - unchanged on simultaneous push and pop, or on neither
- out_data = storage[rd_ptr]; out_valid = !empty.
- Full with out_ready=1: the pop happens, but in_ready is still 0 that cycle, so there is no push. in_ready rises the next cycle.
- Empty: no pop is possible. A push makes the entry visible on the next cycle.
- in_valid held while in_ready=0: no state change. The producer must hold in_data and in_valid stable until accepted.
- out_ready without out_valid: ignored.
- Reset, including assertion mid-transfer:
  - pointers = 0, count = 0
  - all storage entries = 0
  - empty=1, full=0, in_ready=1, out_valid=0, out_data=0
  - in-flight data is discarded
- Deassertion of rst is synchronous to clk; the first push is accepted on the first rising edge with rst low.

## Timing
- All outputs are registered-state derived. There is no combinational path from in_* to out_*, or from out_ready to in_ready, except in bypass mode (see Configuration).
- Input-to-output latency is 1 cycle: a word pushed at edge N appears on out_data with out_valid=1 after edge N.
- Sustained throughput is 1 word/cycle when the consumer keeps out_ready=1.
- count, full and empty change only at rising clk edges, or asynchronously on rst assertion.

## Configuration
- VXE_REG_FIFO_BYPASS_EN
- **Defined:**
  - When empty=1, in_valid=1 and out_ready=1, in_data passes combinationally to out_data with out_valid=1.
  - The word is consumed in that same cycle without being stored; pointers and count are unchanged.
  - When empty=1 and out_ready=0, the word is stored normally.
  - The bypass creates combinational paths in_valid→out_valid and in_data→out_data.
- **Undefined:**
  - No bypass; latency is always 1 cycle, as described in Timing.

## Test plan
- **Reset values:** assert rst for 3 cycles mid-stream after pushing 2 words → count=0, empty=1, full=0, in_ready=1, out_valid=0, out_data=0; the pre-reset words never appear.
- **Single word:** with out_ready=0, push 32'hfefe_0000 → next cycle out_valid=1, out_data=32'hfefe_0000, count=1; then out_ready=1 for one cycle → empty=1.
- **Fill and stall:** DEPTH=4, out_ready=0, push 0x1..0x5 back-to-back →
  - 0x1–0x4 are accepted; full=1, in_ready=0, count=4 after the 4th.
  - 0x5 is held off; in_ready=1 in the cycle after the first pop.
  - The consumer then reads 0x1, 0x2, 0x3, 0x4, 0x5 in order.
- **Wrap-around streaming:** push 32'hbebe_0000+i for i=0..11 with out_ready toggling 1,1,0 → all 12 words are received in order with no loss or duplication; count never exceeds 4.
- **Simultaneous push/pop at count=2:** one cycle with push and pop both active → count stays 2; the head advances to the next word.
- **Bypass, macro defined:** empty FIFO, in_valid=1, out_ready=1, in_data=32'h1234_5678 → out_valid=1 and out_data=32'h1234_5678 in the same cycle; count stays 0. Without the macro, the word appears one cycle later.
